// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift frame sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // A zero or oversized length asks for a full-width frame.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Loadable bidirectional shift register with serial in and async active-low clear.
module shift_core
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so a new frame always starts from the host word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      if (dir == DIR_RIGHT) begin
        q <= {ser_in, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], ser_in};
      end
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame sequencer: request handshake, serial shift of a loaded word, response handshake.
// Optional abort input/aborted pulse enabled by defining SHIFT_SEQ_CTRL_ABORT_EN.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [CNT_W-1:0] req_len,
  input  logic [WIDTH-1:0] req_data,
  input  logic             stall,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             shift_active,
  output logic             resp_valid,
  input  logic             resp_ready,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] resp_data
);

  state_t           state;
  logic             dir;
  logic [CNT_W-1:0] cnt;
  logic             ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [WIDTH-1:0] sr;
  logic             accept;
  logic             shift_go;
  logic [CNT_W-1:0] req_cnt;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic             aborted_q;
`endif

  assign accept   = (state == IDLE) && req_valid && ready_q;
  assign req_cnt  = CNT_W'(eff_len(32'(req_len), WIDTH));
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  assign shift_go = (state == SHIFT) && !stall && !abort;
`else
  assign shift_go = (state == SHIFT) && !stall;
`endif

  shift_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(req_data),
    .shift_en (shift_go),
    .dir      (dir),
    .ser_in   (ser_in),
    .q        (sr)
  );

  // The response is registered one edge after entering DONE, giving L+1 edges of latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      dir          <= DIR_LEFT;
      cnt          <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
      aborted_q    <= 1'b0;
`endif
    end else begin
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q <= 1'b0;
            dir     <= req_dir;
            cnt     <= req_cnt;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
          if (abort) begin
            cnt       <= '0;
            ready_q   <= 1'b1;
            aborted_q <= 1'b1;
            state     <= IDLE;
          end else
`endif
          if (!stall) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (!resp_valid_q) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= sr;
          end else if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            ready_q      <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign shift_active = shift_go;
  assign ser_out      = (state == SHIFT) ? ((dir == DIR_RIGHT) ? sr[0] : sr[WIDTH-1]) : 1'b0;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  assign aborted      = aborted_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: directed frames, monitor checks responses and latency.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               expEdge;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             req_dir;
  logic [CNT_W-1:0] req_len;
  logic [WIDTH-1:0] req_data;
  logic             stall;
  logic             ser_in;
  logic             ser_out;
  logic             shift_active;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  exp_t sbQueue[$];
  exp_t monExp;
  int   checks = 0;
  int   errors = 0;
  int   edgeCount = 0;
  logic prevValid = 1'b0;

  shift_seq_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_dir     (req_dir),
    .req_len     (req_len),
    .req_data    (req_data),
    .stall       (stall),
    .ser_in      (ser_in),
    .ser_out     (ser_out),
    .shift_active(shift_active),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    .abort       (abort),
    .aborted     (aborted),
`endif
    .resp_data   (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCount++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every rising resp_valid pops one expected response.
  always @(negedge clk) begin
    if (resp_valid && !prevValid) begin
      if (sbQueue.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_resp actual=%0h expected=none", resp_data);
      end else begin
        monExp = sbQueue.pop_front();
        checkOutput("resp_data", 32'(resp_data), 32'(monExp.data));
        checkOutput("resp_latency", edgeCount, monExp.expEdge);
      end
    end
    prevValid = resp_valid;
  end

  // Issues one frame from a negedge; cutAfter >= 0 stops after that many shifts.
  task automatic applyStimulus(input logic d, input logic [CNT_W-1:0] len, input logic [WIDTH-1:0] data,
                               input logic sIn, input logic [WIDTH-1:0] expData,
                               input int stallAt, input int stallCycles, input int cutAfter);
    int   effL;
    int   waitCycles;
    int   acceptEdge;
    logic expBit;
    effL = ((len == 0) || (len > WIDTH)) ? WIDTH : int'(len);
    req_valid = 1'b1;
    req_dir   = d;
    req_len   = len;
    req_data  = data;
    ser_in    = sIn;
    waitCycles = 0;
    while (!req_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acceptEdge = edgeCount;
    req_valid = 1'b0;
    req_data  = ~data;
    req_dir   = ~d;
    req_len   = 4'd1;
    if (cutAfter < 0) sbQueue.push_back('{expData, acceptEdge + effL + 1 + stallCycles});
    checkOutput("req_ready_busy", req_ready, 0);
    for (int i = 0; i < effL; i++) begin
      if (cutAfter == i) return;
      expBit = d ? data[i] : data[WIDTH-1-i];
      if (i == stallAt) begin
        for (int s = 0; s < stallCycles; s++) begin
          stall = 1'b1;
          #1;
          checkOutput("ser_out_stall", ser_out, expBit);
          checkOutput("shift_active_stall", shift_active, 0);
          @(negedge clk);
        end
      end
      stall = 1'b0;
      #1;
      checkOutput("ser_out", ser_out, expBit);
      checkOutput("shift_active", shift_active, 1);
      @(negedge clk);
    end
    checkOutput("ser_out_done", ser_out, 0);
    checkOutput("shift_active_done", shift_active, 0);
    waitCycles = 0;
    while (!resp_valid && waitCycles < 10) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!resp_valid) begin
      checkOutput("resp_timeout", 0, 1);
      return;
    end
    checkOutput("req_ready_done", req_ready, 0);
    if (resp_ready) begin
      @(negedge clk);
      checkOutput("resp_valid_cleared", resp_valid, 0);
      checkOutput("req_ready_idle", req_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    req_valid  = 1'b1;
    req_dir    = 1'b0;
    req_len    = 4'd8;
    req_data   = 8'hA5;
    stall      = 1'b0;
    ser_in     = 1'b0;
    resp_ready = 1'b1;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    abort      = 1'b0;
`endif

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_ser_out", ser_out, 0);
      checkOutput("rst_shift_active", shift_active, 0);
      checkOutput("rst_resp_valid", resp_valid, 0);
      checkOutput("rst_resp_data", 32'(resp_data), 0);
    end
    rst       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_req_ready", req_ready, 1);

    applyStimulus(1'b0, 4'd8, 8'hA5, 1'b0, 8'h00, -1, 0, -1);
    applyStimulus(1'b1, 4'd4, 8'h0F, 1'b1, 8'hF0, -1, 0, -1);
    applyStimulus(1'b1, 4'd0, 8'h0F, 1'b1, 8'hFF, -1, 0, -1);
    applyStimulus(1'b0, 4'd8, 8'h81, 1'b1, 8'hFF, 2, 3, -1);

    // Backpressure: response held while a competing request is offered.
    resp_ready = 1'b0;
    applyStimulus(1'b0, 4'd3, 8'hC5, 1'b1, 8'h2F, -1, 0, -1);
    req_valid = 1'b1;
    req_data  = 8'h11;
    req_len   = 4'd1;
    req_dir   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_resp_valid", resp_valid, 1);
      checkOutput("bp_resp_data", 32'(resp_data), 32'h2F);
      checkOutput("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("bp_release_valid", resp_valid, 0);
    checkOutput("bp_release_ready", req_ready, 1);
    checkOutput("bp_no_accept_shift", shift_active, 0);

    applyStimulus(1'b1, 4'd9, 8'h96, 1'b0, 8'h00, -1, 0, -1);

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1'b0, 4'd8, 8'h5A, 1'b0, 8'h00, -1, 0, 3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_ser_out", ser_out, 0);
    checkOutput("mid_rst_shift_active", shift_active, 0);
    checkOutput("mid_rst_req_ready", req_ready, 0);
    checkOutput("mid_rst_resp_valid", resp_valid, 0);
    checkOutput("mid_rst_resp_data", 32'(resp_data), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_release_ready", req_ready, 1);
    applyStimulus(1'b0, 4'd8, 8'h3C, 1'b0, 8'h00, -1, 0, -1);

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    applyStimulus(1'b0, 4'd8, 8'h3C, 1'b0, 8'h00, -1, 0, 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_pulse", aborted, 1);
    checkOutput("abort_req_ready", req_ready, 1);
    checkOutput("abort_resp_valid", resp_valid, 0);
    checkOutput("abort_shift_active", shift_active, 0);
    @(negedge clk);
    checkOutput("abort_pulse_end", aborted, 0);
    checkOutput("abort_no_resp", resp_valid, 0);
    applyStimulus(1'b1, 4'd2, 8'h3C, 1'b0, 8'h0F, -1, 0, -1);
`endif

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_empty", sbQueue.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Frame sequencer around a loadable bidirectional shift register.
- Accepts a parallel word plus shift direction and bit count over a valid/ready request handshake.
- Shifts the word out serially while capturing serial input into the vacated end.
- Returns the final register contents over a valid/ready response handshake. Sits between a host-side register interface and a bit-serial link.

Parameters:
- WIDTH, 8, shift register width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), width of the length field. Localparam, derived, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  controller can accept a request.
- req_dir  input  1  0 = shift left (MSB out, ser_in into bit 0); 1 = shift right (bit 0 out, ser_in into MSB).
- req_len  input  CNT_W  number of bits to shift; 0 or >WIDTH means WIDTH.
- req_data  input  WIDTH  parallel word to load.
- stall  input  1  pauses shifting while high.
- ser_in  input  1  serial data captured on each shift edge.
- ser_out  output  1  current outgoing bit.
- shift_active  output  1  high in cycles where a shift occurs on the next edge.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  WIDTH  register contents after the frame.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE immediately.
  - Shift register and count clear to 0.
  - All outputs are 0: req_ready, ser_out, shift_active, resp_valid, resp_data.
  - req_ready rises in the first IDLE cycle after rst goes high.
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at an edge: load sr<=req_data, latch dir, cnt<=effective length, go to SHIFT.
- SHIFT:
  - req_ready=0. shift_active = !stall.
  - ser_out = sr[WIDTH-1] if dir=0, sr[0] if dir=1 (combinational from sr).
  - On each edge with !stall:
    - dir=0: sr<={sr[WIDTH-2:0],ser_in}.
    - dir=1: sr<={ser_in,sr[WIDTH-1:1]}.
    - cnt<=cnt-1.
  - The edge that shifts with cnt==1 moves to DONE.
  - stall high: sr, cnt and ser_out hold; no shift.
- DONE:
  - resp_valid=1, resp_data=sr, ser_out=0, req_ready=0.
  - resp_data is stable until resp_ready is sampled high, then go to IDLE.
  - New requests are never accepted in DONE, including the cycle resp_ready is high.
- ser_out and shift_active are 0 outside SHIFT. resp_data reads 0 outside DONE.
- Latency: with no stall, resp_valid asserts exactly L+1 edges after the accepting edge (L = effective length). Each stall cycle adds 1.
- Changes to req_* inputs outside the accepting edge have no effect.

Optional Feature:
- Macro SHIFT_SEQ_CTRL_ABORT_EN.
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort high at an edge in SHIFT, with or without stall, goes straight to IDLE without entering DONE.
  - aborted pulses high for exactly one cycle, the first IDLE cycle.
  - abort is ignored in IDLE and DONE.
- Undefined: neither port exists; frames always run to completion.

Decomposition:
- Package shift_seq_pkg:
  - state_t enum (IDLE, SHIFT, DONE).
  - Constants DIR_LEFT=1'b0, DIR_RIGHT=1'b1.
- Sub-module shift_core: WIDTH-bit register with synchronous load, bidirectional shift-enable, serial in/out, async active-low clear.
- shift_seq_ctrl holds the FSM, counter and handshakes, and instantiates shift_core once.

Test Plan:
- Reset: hold rst low 3 cycles with req_valid=1 -> every output 0, no accept; release -> req_ready=1 next cycle.
- Left, WIDTH=8, data=8'hA5, len=8, ser_in=0, resp_ready=1 -> ser_out sequence 1,0,1,0,0,1,0,1; resp_valid on edge 9 after accept; resp_data=8'h00.
- Right, data=8'h0F, len=4, ser_in=1 -> ser_out 1,1,1,1; resp_data=8'hF0; len=0 with the same data -> 8 shifts, resp_data=8'hFF.
- Stall: left, data=8'h81, len=8; stall high 3 cycles after the 2nd shift -> ser_out held at the same bit for those cycles, shift_active=0, resp_valid on edge 12.
- Backpressure: resp_ready=0 for 5 cycles in DONE with req_valid=1 -> resp_valid/resp_data stable, req_ready=0; resp_ready=1 -> IDLE next edge, then new request accepted.
- Async reset mid-frame: assert rst between edges after 3 shifts -> outputs 0 without waiting for clk; release and send data=8'h3C, len=8 left -> normal completion. With ABORT_EN: abort after 3 shifts -> no resp_valid, aborted one-cycle pulse.
